// File: rtl/next_pc_gen.sv
// Next-PC generator: sequential/predicted fetch issue, in-order prediction queue,
// branch-cache update and mispredict/exception redirect.
module next_pc_gen #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PQ_DEPTH = 4
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iFLUSH,
   input  logic [31:0] iFLUSH_ADDR,
   output logic        oFETCH_REQ,
   output logic [31:0] oFETCH_ADDR,
   input  logic        iFETCH_BUSY,
   output logic        oBC_SEARCH_STB,
   output logic [31:0] oBC_SEARCH_ADDR,
   input  logic        iBC_SEARCH_HIT,
   input  logic        iBC_PREDICT_BRANCH,
   input  logic [31:0] iBC_SEARCH_ADDR,
   output logic        oBC_JUMP_STB,
   output logic        oBC_JUMP_HIT,
   output logic [31:0] oBC_JUMP_ADDR,
   output logic [31:0] oBC_JUMP_INST_ADDR,
   output logic        oBC_FLUSH,
   input  logic        iEXE_VALID,
   input  logic        iEXE_BRANCH,
   input  logic        iEXE_TAKEN,
   input  logic [31:0] iEXE_TARGET,
   output logic        oPIPE_FLUSH
);

   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_REDIRECT = 1'b1;

   logic [0:0]  r_state;
   logic [31:0] r_pc;

   // Prediction queue: one entry per issued fetch, retired in program order.
   logic [31:0] r_q_pc [0:PQ_DEPTH-1];
   logic        r_q_pt [0:PQ_DEPTH-1];
   logic [31:0] r_q_pa [0:PQ_DEPTH-1];
   logic [1:0]  r_wptr;
   logic [1:0]  r_rptr;
   logic [2:0]  r_count;

   logic        r_jump_stb;
   logic        r_jump_hit;
   logic [31:0] r_jump_addr;
   logic [31:0] r_jump_inst;
   logic        r_pipe_flush;

   logic        w_full;
   logic        w_empty;
   logic        w_issue;
   logic        w_pred_taken;
   logic [31:0] w_seq_pc;
   logic        w_pop;
   logic [31:0] w_head_pc;
   logic        w_head_pt;
   logic [31:0] w_head_pa;
   logic        w_mispredict;
   logic        w_update;
   logic [31:0] w_redirect_pc;

   assign w_full  = (r_count == 3'(PQ_DEPTH));
   assign w_empty = (r_count == 3'd0);

   // Gating with inRESET keeps the request strobes low for the whole reset window.
   assign w_issue      = inRESET & (r_state == ST_RUN) & ~iFETCH_BUSY & ~w_full;
   assign w_pred_taken = iBC_SEARCH_HIT & iBC_PREDICT_BRANCH;
   assign w_seq_pc     = w_pred_taken ? iBC_SEARCH_ADDR : (r_pc + 32'd4);

   assign w_pop     = iEXE_VALID & ~w_empty;
   assign w_head_pc = r_q_pc[r_rptr];
   assign w_head_pt = r_q_pt[r_rptr];
   assign w_head_pa = r_q_pa[r_rptr];

   assign w_mispredict = w_pop &
                         ((iEXE_BRANCH & (iEXE_TAKEN != w_head_pt)) |
                          (iEXE_BRANCH & iEXE_TAKEN & (iEXE_TARGET != w_head_pa)) |
                          (~iEXE_BRANCH & w_head_pt));

   assign w_update      = w_pop & iEXE_BRANCH & ~iFLUSH;
   assign w_redirect_pc = (iEXE_TAKEN & iEXE_BRANCH) ? iEXE_TARGET : (w_head_pc + 32'd4);

   assign oFETCH_REQ         = w_issue;
   assign oFETCH_ADDR        = r_pc;
   assign oBC_SEARCH_STB     = w_issue;
   assign oBC_SEARCH_ADDR    = r_pc;
   assign oBC_JUMP_STB       = r_jump_stb;
   assign oBC_JUMP_HIT       = r_jump_hit;
   assign oBC_JUMP_ADDR      = r_jump_addr;
   assign oBC_JUMP_INST_ADDR = r_jump_inst;
   assign oBC_FLUSH          = iFLUSH;
   assign oPIPE_FLUSH        = r_pipe_flush;

   // Entry payload needs no reset: pointers and count define which entries are live.
   always_ff @(posedge iCLOCK) begin
      if (w_issue) begin
         r_q_pc[r_wptr] <= r_pc;
         r_q_pt[r_wptr] <= w_pred_taken;
         r_q_pa[r_wptr] <= iBC_SEARCH_ADDR;
      end
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_jump_stb  <= 1'b0;
         r_jump_hit  <= 1'b0;
         r_jump_addr <= 32'h0;
         r_jump_inst <= 32'h0;
      end else begin
         r_jump_stb <= w_update;
         if (w_update) begin
            r_jump_hit  <= ~iEXE_TAKEN;
            r_jump_addr <= iEXE_TARGET;
            r_jump_inst <= w_head_pc;
         end
      end
   end

   // Exception flush has priority over a mispredict resolved in the same cycle.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_state      <= ST_RUN;
         r_pc         <= RESET_PC;
         r_wptr       <= 2'd0;
         r_rptr       <= 2'd0;
         r_count      <= 3'd0;
         r_pipe_flush <= 1'b0;
      end else begin
         r_pipe_flush <= 1'b0;
         if (iFLUSH) begin
            r_pc    <= iFLUSH_ADDR;
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
            r_state <= ST_REDIRECT;
         end else if (w_mispredict) begin
            r_pc         <= w_redirect_pc;
            r_wptr       <= 2'd0;
            r_rptr       <= 2'd0;
            r_count      <= 3'd0;
            r_pipe_flush <= 1'b1;
            r_state      <= ST_REDIRECT;
         end else begin
            r_state <= ST_RUN;
            if (w_issue) begin
               r_pc   <= w_seq_pc;
               r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
               r_rptr <= r_rptr + 2'd1;
            end
            case ({w_issue, w_pop})
               2'b10:   r_count <= r_count + 3'd1;
               2'b01:   r_count <= r_count - 3'd1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

`ifndef SYNTHESIS
   a_count_bound : assert property (@(posedge iCLOCK) disable iff (!inRESET)
      r_count <= 3'(PQ_DEPTH));
   a_no_issue_in_redirect : assert property (@(posedge iCLOCK) disable iff (!inRESET)
      (r_state == ST_REDIRECT) |-> !oFETCH_REQ);
   a_redirect_one_cycle : assert property (@(posedge iCLOCK) disable iff (!inRESET)
      (r_state == ST_REDIRECT && !iFLUSH) |=> (r_state == ST_RUN));
   a_pipe_flush_pulse : assert property (@(posedge iCLOCK) disable iff (!inRESET)
      oPIPE_FLUSH |=> !oPIPE_FLUSH);
`endif

endmodule

// File: doc/next_pc_gen.md
NEXT_PC_GEN -- requirements
Module: next_pc_gen

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded at reset.
REQ-002 The block SHALL have parameter PQ_DEPTH, default 4, meaning prediction-queue entries; only the value 4 is supported, with 2-bit pointers.
REQ-003 Ports, in order (name, direction, width, meaning):
- iCLOCK input 1: the single clock.
- inRESET input 1: asynchronous active-low reset.
- iFLUSH input 1: exception/interrupt redirect.
- iFLUSH_ADDR input 32: redirect target.
- oFETCH_REQ output 1: fetch request strobe.
- oFETCH_ADDR output 32: fetch address.
- iFETCH_BUSY input 1: fetch unit cannot accept a request this cycle.
- oBC_SEARCH_STB output 1: branch-cache search strobe.
- oBC_SEARCH_ADDR output 32: search instruction address.
- iBC_SEARCH_HIT input 1: branch-cache hit, same cycle as the search.
- iBC_PREDICT_BRANCH input 1: predicted taken, same cycle.
- iBC_SEARCH_ADDR input 32: predicted target, same cycle.
- oBC_JUMP_STB output 1: branch-cache update strobe.
- oBC_JUMP_HIT output 1: resolved not-taken (the branch cache counter decrements on 1).
- oBC_JUMP_ADDR output 32: resolved target.
- oBC_JUMP_INST_ADDR output 32: branch instruction address.
- oBC_FLUSH output 1: branch-cache flush.
- iEXE_VALID input 1: in-order instruction resolution strobe.
- iEXE_BRANCH input 1: the resolved instruction is a branch.
- iEXE_TAKEN input 1: the branch was taken.
- iEXE_TARGET input 32: actual branch target.
- oPIPE_FLUSH output 1: mispredict pipeline kill.

Function
REQ-004 State machine: RUN and REDIRECT; reset state is RUN.
REQ-005 In RUN, issue is enabled when iFETCH_BUSY=0 and the queue is not full; issue is combinational.
- oFETCH_REQ=1, oFETCH_ADDR=b_pc.
- oBC_SEARCH_STB=1, oBC_SEARCH_ADDR=b_pc.
REQ-006 When issue is disabled, or in REDIRECT, oFETCH_REQ=0 and oBC_SEARCH_STB=0, and b_pc SHALL hold.
REQ-007 On issue:
- pred_taken = iBC_SEARCH_HIT & iBC_PREDICT_BRANCH.
- b_pc <= pred_taken ? iBC_SEARCH_ADDR : b_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0).
- Push {b_pc, pred_taken, iBC_SEARCH_ADDR} to the queue tail.
REQ-008 Queue is a 4-entry FIFO with wrapping 2-bit read/write pointers and a 3-bit count.
- Full at count=4: issue disabled.
- Empty at count=0: pops ignored.
- Simultaneous push and pop: count unchanged.
REQ-009 On iEXE_VALID with the queue non-empty, pop the head entry.
- mispredict = (iEXE_BRANCH & (iEXE_TAKEN != head.pred_taken)) | (iEXE_BRANCH & iEXE_TAKEN & iEXE_TARGET != head.pred_addr) | (!iEXE_BRANCH & head.pred_taken).
REQ-010 Branch-cache update on a popped entry with iEXE_BRANCH=1, registered, 1-cycle pulse in the next cycle:
- oBC_JUMP_STB=1.
- oBC_JUMP_HIT=!iEXE_TAKEN.
- oBC_JUMP_ADDR=iEXE_TARGET.
- oBC_JUMP_INST_ADDR=head.pc.
REQ-011 On mispredict:
- b_pc <= iEXE_TAKEN&iEXE_BRANCH ? iEXE_TARGET : head.pc+4.
- Queue cleared (pointers and count to 0); any same-cycle push is discarded.
- oPIPE_FLUSH=1 for exactly the next cycle.
- State -> REDIRECT.
REQ-012 REDIRECT lasts exactly one cycle with no issue, then -> RUN unconditionally.
REQ-013 On iFLUSH=1, registered:
- b_pc <= iFLUSH_ADDR.
- Queue cleared; push/pop that cycle ignored.
- oBC_JUMP_STB suppressed next cycle.
- State -> REDIRECT.
- oBC_FLUSH=iFLUSH combinationally.
REQ-014 iFLUSH and mispredict in the same cycle: iFLUSH wins; oPIPE_FLUSH SHALL NOT pulse.
REQ-015 iEXE_VALID with an empty queue SHALL produce no update, no flush, and no state change.

Reset
REQ-016 While inRESET=0, asynchronously:
- b_pc=RESET_PC; state RUN; queue pointers and count 0.
- oBC_JUMP_STB=0, oBC_JUMP_HIT=0, oBC_JUMP_ADDR=0, oBC_JUMP_INST_ADDR=0, oPIPE_FLUSH=0.
- oFETCH_REQ and oBC_SEARCH_STB are 0 only while reset is asserted.
REQ-017 Reset asserted mid-operation SHALL discard all queued predictions and pending update/flush pulses; the first issue after release is at RESET_PC.

Verification
REQ-018 Release reset, iFETCH_BUSY=0, branch cache always misses -> oFETCH_ADDR sequence 0,4,8,12; issue stalls after 4 requests with no iEXE_VALID.
REQ-019 Search at 0x10 returns hit=1, predict=1, addr=0x200 -> next oFETCH_ADDR=0x200; resolving iEXE_BRANCH=1, TAKEN=1, TARGET=0x200 -> no oPIPE_FLUSH; oBC_JUMP_STB pulses with HIT=0, INST_ADDR=0x10.
REQ-020 Prediction not-taken at 0x20, resolved taken to 0x400 -> oPIPE_FLUSH 1 cycle, queue count 0, one idle cycle, then oFETCH_ADDR=0x400.
REQ-021 iFLUSH=1 with iFLUSH_ADDR=0x8000 in the same cycle as a mispredict -> oBC_FLUSH=1, no oPIPE_FLUSH, no oBC_JUMP_STB, next issue at 0x8000.
REQ-022 Hold iFETCH_BUSY=1 for 3 cycles -> oFETCH_ADDR stable, no push; simultaneous push and pop with count 4 is impossible (full blocks push); with count 2 the count stays 2.
REQ-023 Assert inRESET low mid-stream with 3 entries queued -> all outputs at reset values immediately; after release, the first fetch is at RESET_PC.
